// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// 4-bit two-level carry-lookahead slice with group propagate/generate.
// Latency: purely combinational.
// Backpressure: none; no state.
module cla4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3,
    output logic                group_p,
    output logic                group_g
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products, so no carry waits on another.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

    assign group_p = &p;
    assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);

    assign co = group_g | (group_p & ci);
    assign s  = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder processing one nibble per clock through a single CLA slice.
// Latency: result valid NIB+1 cycles after the input handshake.
// Backpressure: holds results in DONE until out_ready; accepts only in IDLE.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NIB - 1);

    generate
        if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [WIDTH-1:0]     sum_r;
    logic                 carry;
    logic                 acc_p;
    logic                 acc_g;
    logic                 cout_r;
    logic                 ovf_r;

    logic [NIBBLE_W-1:0]  sl_s;
    logic                 sl_co;
    logic                 sl_c3;
    logic                 sl_p;
    logic                 sl_g;
    logic [WIDTH+NIBBLE_W-1:0] sum_cat;
    logic                 last_step;

    cla4_slice u_slice (
        .a       (a_sh[NIBBLE_W-1:0]),
        .b       (b_sh[NIBBLE_W-1:0]),
        .ci      (carry),
        .s       (sl_s),
        .co      (sl_co),
        .c3      (sl_c3),
        .group_p (sl_p),
        .group_g (sl_g)
    );

    // New nibble enters at the top; after NIB steps the low nibble sits at bit 0.
    assign sum_cat   = {sl_s, sum_r};
    assign last_step = (cnt == LAST_STEP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            acc_p  <= 1'b0;
            acc_g  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        acc_p <= 1'b1;
                        acc_g <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    carry <= sl_co;
                    acc_p <= acc_p & sl_p;
                    // Fold this (more significant) nibble on top of the lower group.
                    acc_g <= sl_g | (sl_p & acc_g);
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        cout_r <= sl_co;
                        ovf_r  <= sl_c3 ^ sl_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign grp_p     = acc_p;
    assign grp_g     = acc_g;

endmodule
